// File: rtl/act_group_packer_pkg.sv
// Shared types and defaults for the activation group packer.
// The defaults match the dispatcher activation port.
package act_group_packer_pkg;

  localparam int DATA_WIDTH_DEF             = 8;
  localparam int GROUP_SIZE_DEF             = 4;
  localparam int LOG_MAX_ITERS_DEF          = 16;
  localparam int LOG_MAX_READS_PER_ITER_DEF = 16;
  localparam int ZERO_INFO_DEF              = GROUP_SIZE_DEF;
  localparam int GROUP_W = DATA_WIDTH_DEF * GROUP_SIZE_DEF + ZERO_INFO_DEF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONFIG = 2'd1,
    RUN    = 2'd2
  } state_t;

  // Bit j is set when lane j of a packed default-width group is zero.
  function automatic logic [ZERO_INFO_DEF-1:0] pack_zero_info(
    input logic [DATA_WIDTH_DEF*GROUP_SIZE_DEF-1:0] lanes
  );
    logic [ZERO_INFO_DEF-1:0] z;
    z = '0;
    for (int j = 0; j < GROUP_SIZE_DEF; j++) begin
      z[j] = (lanes[j*DATA_WIDTH_DEF +: DATA_WIDTH_DEF] == '0);
    end
    return z;
  endfunction

endpackage

// File: rtl/act_group_packer_slot.sv
// Single-entry valid/avail output register holding one packed group word.
// A clear discards the held word; a load always wins over a same-cycle take.
module act_out_slot
  import act_group_packer_pkg::*;
#(
  parameter int WIDTH = GROUP_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_take,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_clear) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
    end else if (r_valid && i_take) begin
      r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/act_group_packer.sv
// Packs GROUP_SIZE scalar activations into {zero_info, lanes} words for the
// dispatcher, counting groups per iteration and pulsing done after the last.
module act_group_packer
  import act_group_packer_pkg::*;
#(
  parameter int DATA_WIDTH             = DATA_WIDTH_DEF,
  parameter int GROUP_SIZE             = GROUP_SIZE_DEF,
  parameter int LOG_MAX_ITERS          = LOG_MAX_ITERS_DEF,
  parameter int LOG_MAX_READS_PER_ITER = LOG_MAX_READS_PER_ITER_DEF,
  parameter int ZERO_INFO              = GROUP_SIZE
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        configure,
  input  logic [LOG_MAX_ITERS-1:0]                    num_iters,
  input  logic [LOG_MAX_READS_PER_ITER-1:0]           num_reads_per_iter,
  input  logic [DATA_WIDTH-1:0]                       data_in,
  input  logic                                        valid_in,
  output logic                                        avail_out,
  output logic [DATA_WIDTH*GROUP_SIZE+ZERO_INFO-1:0]  act_data_out,
  output logic                                        act_valid_out,
  input  logic                                        act_avail_in,
  output logic                                        done
);

  localparam int LANES_W    = DATA_WIDTH * GROUP_SIZE;
  localparam int GROUP_BITS = LANES_W + ZERO_INFO;
  localparam int CNT_W      = $clog2(GROUP_SIZE + 1);
  localparam int IDX_W      = (GROUP_SIZE > 1) ? $clog2(GROUP_SIZE) : 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(GROUP_SIZE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GROUP_SIZE - 1);

  state_t r_state, w_state_next;
  logic [CNT_W-1:0]                  r_cnt;
  logic [IDX_W-1:0]                  w_idx;
  logic [LANES_W-1:0]                r_lanes, w_lanes;
  logic [ZERO_INFO-1:0]              r_zero, w_zero;
  logic [LOG_MAX_ITERS-1:0]          r_num_iters, r_iter, r_col_iter, w_iters_m1;
  logic [LOG_MAX_READS_PER_ITER-1:0] r_num_reads, r_group, r_col_group, w_reads_m1;
  logic r_last_col, r_done, w_done_next;
  logic w_run, w_accept, w_full, w_slot_valid, w_slot_free;
  logic w_handoff, w_out_accept, w_final, w_col_final, w_cfg_zero;

  assign w_run        = (r_state == RUN) && !configure;
  assign avail_out    = w_run && (r_cnt < CNT_FULL) && !r_last_col;
  assign w_accept     = valid_in && avail_out;
  assign w_full       = (r_cnt == CNT_FULL) || ((r_cnt == CNT_LAST) && w_accept);
  assign w_slot_free  = !w_slot_valid || act_avail_in;
  assign w_handoff    = w_run && w_full && w_slot_free;
  assign w_out_accept = w_run && w_slot_valid && act_avail_in;
  assign w_iters_m1   = r_num_iters - LOG_MAX_ITERS'(1);
  assign w_reads_m1   = r_num_reads - LOG_MAX_READS_PER_ITER'(1);
  assign w_final      = w_out_accept && (r_group == w_reads_m1) && (r_iter == w_iters_m1);
  assign w_col_final  = w_handoff && (r_col_group == w_reads_m1) && (r_col_iter == w_iters_m1);
  assign w_cfg_zero   = (r_num_iters == '0) || (r_num_reads == '0);
  assign w_idx        = r_cnt[IDX_W-1:0];

  // The group handed off includes the lane being accepted this very cycle.
  always_comb begin
    w_lanes = r_lanes;
    w_zero  = r_zero;
    if (w_accept) begin
      w_lanes[w_idx*DATA_WIDTH +: DATA_WIDTH] = data_in;
      w_zero[w_idx] = (data_in == '0);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_done_next  = 1'b0;
    if (configure) begin
      w_state_next = CONFIG;
    end else begin
      case (r_state)
        IDLE:   w_state_next = IDLE;
        CONFIG: begin
          if (w_cfg_zero) begin
            w_state_next = IDLE;
            w_done_next  = 1'b1;
          end else begin
            w_state_next = RUN;
          end
        end
        RUN: begin
          if (w_final) begin
            w_state_next = IDLE;
            w_done_next  = 1'b1;
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_done_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_lanes <= '0;
      r_zero  <= '0;
    end else if (configure) begin
      r_cnt   <= '0;
      r_lanes <= '0;
      r_zero  <= '0;
    end else begin
      r_lanes <= w_lanes;
      r_zero  <= w_zero;
      if (w_handoff) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Output-side counters track accepted groups; collector-side ones track
  // handed-off groups so input stops once the final group is collected.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_num_iters <= '0;
      r_num_reads <= '0;
      r_group     <= '0;
      r_iter      <= '0;
      r_col_group <= '0;
      r_col_iter  <= '0;
      r_last_col  <= 1'b0;
    end else if (configure) begin
      r_num_iters <= num_iters;
      r_num_reads <= num_reads_per_iter;
      r_group     <= '0;
      r_iter      <= '0;
      r_col_group <= '0;
      r_col_iter  <= '0;
      r_last_col  <= 1'b0;
    end else begin
      if (w_out_accept) begin
        if (r_group == w_reads_m1) begin
          r_group <= '0;
          r_iter  <= r_iter + LOG_MAX_ITERS'(1);
        end else begin
          r_group <= r_group + LOG_MAX_READS_PER_ITER'(1);
        end
      end
      if (w_handoff) begin
        if (r_col_group == w_reads_m1) begin
          r_col_group <= '0;
          r_col_iter  <= r_col_iter + LOG_MAX_ITERS'(1);
        end else begin
          r_col_group <= r_col_group + LOG_MAX_READS_PER_ITER'(1);
        end
        if (w_col_final) begin
          r_last_col <= 1'b1;
        end
      end
    end
  end

  act_out_slot #(
    .WIDTH(GROUP_BITS)
  ) u_slot (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_clear (configure),
    .i_load  (w_handoff),
    .i_data  ({w_zero, w_lanes}),
    .i_take  (w_out_accept),
    .o_data  (act_data_out),
    .o_valid (w_slot_valid)
  );

  assign act_valid_out = w_slot_valid;
  assign done          = r_done;

endmodule
